st_wbuf: RTL

ST_WBUF -- requirements
Module: st_wbuf

---
 rtl/st_wbuf.sv | 79 +++++++
 1 files changed

// File: rtl/st_wbuf.sv
// st_wbuf: circular store write buffer draining to the Dcache, with coalescing
// of back-to-back stores to the same address and youngest-match load forwarding.
module st_wbuf #(
   parameter int ADDR_W   = 64,
   parameter int WB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_ret_en_i,
   input  logic [ADDR_W-1:0] st_ret_addr_i,
   input  logic [63:0]       st_ret_data_i,
   output logic              wb_full_o,
   output logic              wb_empty_o,
   output logic              dc_st_en_o,
   output logic [ADDR_W-1:0] dc_st_addr_o,
   output logic [63:0]       dc_st_data_o,
   input  logic              dc_st_ack_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   output logic              ld_fwd_vld_o,
   output logic [63:0]       ld_fwd_data_o
);
   localparam int PW = $clog2(WB_DEPTH);
   typedef enum logic {IDLE, REQ} state_t;
   state_t            r_state;
   logic [PW:0]       r_head, r_tail;
   logic [ADDR_W-1:0] r_addr [WB_DEPTH];
   logic [63:0]       r_data [WB_DEPTH];
   logic [PW:0]       w_count, w_head_nx, w_tail_nx;
   logic [PW-1:0]     w_yidx, w_fidx;
   logic              w_full, w_empty, w_coal, w_enq, w_pop;
   assign w_full    = (r_head[PW-1:0] == r_tail[PW-1:0]) && (r_head[PW] != r_tail[PW]);
   assign w_empty   = r_head == r_tail;
   assign w_count   = r_tail - r_head;
   assign w_yidx    = r_tail[PW-1:0] - PW'(1);
   // The head entry is being offered to the Dcache, so it may not be rewritten.
   assign w_coal    = st_ret_en_i && !w_full && !w_empty && (r_addr[w_yidx] == st_ret_addr_i) &&
                      ((w_yidx != r_head[PW-1:0]) || (r_state == IDLE));
   assign w_enq     = st_ret_en_i && !w_full && !w_coal;
   assign w_pop     = (r_state == REQ) && dc_st_ack_i;
   assign w_tail_nx = r_tail + (PW+1)'(w_enq);
   assign w_head_nx = r_head + (PW+1)'(w_pop);
   assign wb_full_o    = w_full;
   assign wb_empty_o   = w_empty && (r_state == IDLE);
   assign dc_st_en_o   = r_state == REQ;
   assign dc_st_addr_o = (r_state == REQ) ? r_addr[r_head[PW-1:0]] : '0;
   assign dc_st_data_o = (r_state == REQ) ? r_data[r_head[PW-1:0]] : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_state <= IDLE;
      end else begin
         r_head  <= w_head_nx;
         r_tail  <= w_tail_nx;
         r_state <= (w_head_nx != w_tail_nx) ? REQ : IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_addr[r_tail[PW-1:0]] <= st_ret_addr_i;
         r_data[r_tail[PW-1:0]] <= st_ret_data_i;
      end else if (w_coal) begin
         r_data[w_yidx] <= st_ret_data_i;
      end
   end
   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      ld_fwd_vld_o  = 1'b0;
      ld_fwd_data_o = '0;
      w_fidx        = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         w_fidx = r_head[PW-1:0] + PW'(i);
         if (((PW+1)'(i) < w_count) && (r_addr[w_fidx] == ld_addr_i)) begin
            ld_fwd_vld_o  = 1'b1;
            ld_fwd_data_o = r_data[w_fidx];
         end
      end
   end
endmodule
